relu_maxpool: RTL and testbench

RELU_MAXPOOL -- requirements
Module: relu_maxpool

---
 rtl/relu_maxpool_pkg.sv | 26 ++
 rtl/num_data.sv | 8 +
 rtl/relu_maxpool_max_s.sv | 19 +
 rtl/state_layer_data.sv | 13 +
 rtl/relu_maxpool.sv | 133 +++++++++++++
 tb/tb_relu_maxpool.sv | 258 +++++++++++++++++++++++++
 6 files changed

// File: rtl/relu_maxpool_pkg.sv
// Types and helpers shared by the relu_maxpool block.
//   pool_state_t : row-pair tracking state (EVEN / ODD)
//   activate()   : per-element activation; ReLU when RELU_MAXPOOL_RELU_EN
//                  is defined, identity otherwise
`ifndef NUM_DATA_V
`include "num_data.sv"
`endif

package relu_maxpool_pkg;

    localparam int DATA_W = `DATA_LEN;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pool_state_t;

    function automatic logic signed [DATA_W-1:0] activate(input logic signed [DATA_W-1:0] x);
`ifdef RELU_MAXPOOL_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

endpackage

// File: rtl/num_data.sv
// Shared data-width definition for the datapath blocks.
//   `DATA_LEN : bit width of one signed activation element
`ifndef NUM_DATA_V
`define NUM_DATA_V

`define DATA_LEN 16

`endif

// File: rtl/relu_maxpool_max_s.sv
// max_s: combinational signed two-input maximum.
// Ports:
//   a, b : signed operands, W bits
//   y    : larger of a and b (signed compare)
`ifndef NUM_DATA_V
`include "num_data.sv"
`endif

module max_s #(
    parameter int W = `DATA_LEN
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/state_layer_data.sv
// Shared layer codes driven on cs_layer by the layer sequencer.
//   `LAYER0..`LAYER3 : convolution layers
//   `AFFINE          : fully-connected stage (pooling idle)
`ifndef STATE_LAYER_DATA_V
`define STATE_LAYER_DATA_V

`define LAYER0 4'd0
`define LAYER1 4'd1
`define LAYER2 4'd2
`define LAYER3 4'd3
`define AFFINE 4'd4

`endif

// File: rtl/relu_maxpool.sv
// relu_maxpool: optional ReLU followed by 2x2 signed max-pooling on a
// stream of rows. Horizontal pairs are reduced as each row arrives; the
// first row of a vertical pair is held in a buffer and combined with the
// second row, giving one pooled row per two loads.
//
// Build option: define RELU_MAXPOOL_RELU_EN to clamp negatives to zero
// before pooling; otherwise negative values propagate.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   load       : one-cycle strobe, d holds a valid row
//   cs_layer   : current layer code; a change restarts pairing
//   d          : input row, element (i,j) at (COL*i+j)*`DATA_LEN
//   q          : pooled row, element (i,k) at ((COL/2)*i+k)*`DATA_LEN
//   q_valid    : one-cycle pulse when q is updated
//   layer_done : pulses with the last pooled row of a layer
//
// State | meaning
// EVEN  | no row held, next load is the first row of a pair
// ODD   | first row of a pair held in buffer
`ifndef NUM_DATA_V
`include "num_data.sv"
`endif
`ifndef STATE_LAYER_DATA_V
`include "state_layer_data.sv"
`endif

module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int CH   = 32,
    parameter int COL  = 12,
    parameter int ROWS = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [3:0]                        cs_layer,
    input  logic [CH*COL*`DATA_LEN-1:0]       d,
    output logic [CH*(COL/2)*`DATA_LEN-1:0]   q,
    output logic                              q_valid,
    output logic                              layer_done
);

    localparam int DL    = `DATA_LEN;
    localparam int HC    = COL / 2;
    localparam int NE    = CH * HC;
    localparam int CNT_W = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS / 2 - 1);

    logic [NE*DL-1:0]  h_row;
    logic [NE*DL-1:0]  v_row;
    logic [NE*DL-1:0]  buffer;
    pool_state_t       state;
    logic [CNT_W-1:0]  out_cnt;
    logic [3:0]        cs_prev;

    logic layer_chg;
    logic take_load;
    logic pair_done;

    genvar gi, gk;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            for (gk = 0; gk < HC; gk++) begin : g_col
                logic signed [DL-1:0] a0;
                logic signed [DL-1:0] a1;

                assign a0 = activate(d[(COL*gi + 2*gk)*DL +: DL]);
                assign a1 = activate(d[(COL*gi + 2*gk + 1)*DL +: DL]);

                max_s #(.W(DL)) u_hmax (
                    .a (a0),
                    .b (a1),
                    .y (h_row[(HC*gi + gk)*DL +: DL])
                );

                max_s #(.W(DL)) u_vmax (
                    .a (buffer[(HC*gi + gk)*DL +: DL]),
                    .b (h_row[(HC*gi + gk)*DL +: DL]),
                    .y (v_row[(HC*gi + gk)*DL +: DL])
                );
            end
        end
    endgenerate

    // A layer change in the same cycle as a load makes that load the
    // first row of the new layer, so the held state is overridden here.
    assign layer_chg = (cs_layer != cs_prev);
    assign take_load = load && (cs_layer != `AFFINE);
    assign pair_done = take_load && (state == ODD) && !layer_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            q_valid    <= 1'b0;
            layer_done <= 1'b0;
            state      <= EVEN;
            out_cnt    <= '0;
            buffer     <= '0;
            cs_prev    <= 4'd0;
        end else begin
            cs_prev    <= cs_layer;
            q_valid    <= 1'b0;
            layer_done <= 1'b0;

            if (layer_chg) begin
                state   <= EVEN;
                out_cnt <= '0;
                buffer  <= '0;
            end

            if (take_load) begin
                if (pair_done) begin
                    q       <= v_row;
                    q_valid <= 1'b1;
                    state   <= EVEN;
                    if (out_cnt == CNT_LAST) begin
                        layer_done <= 1'b1;
                        out_cnt    <= '0;
                    end else begin
                        out_cnt <= out_cnt + CNT_W'(1);
                    end
                end else begin
                    buffer <= h_row;
                    state  <= ODD;
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: directed rows are driven and the
// expected pooled row, layer_done flag and arrival cycle are queued; a
// monitor on the falling edge pops and compares on every q_valid.
`ifndef NUM_DATA_V
`include "num_data.sv"
`endif
`ifndef STATE_LAYER_DATA_V
`include "state_layer_data.sv"
`endif

module tb_relu_maxpool;

    localparam int CH   = 32;
    localparam int COL  = 12;
    localparam int ROWS = 12;
    localparam int DL   = `DATA_LEN;
    localparam int HC   = COL / 2;
    localparam int DW   = CH * COL * DL;
    localparam int QW   = CH * HC * DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [3:0]    cs_layer;
    logic [DW-1:0] d;
    logic [QW-1:0] q;
    logic          q_valid;
    logic          layer_done;

    always #5 clk = ~clk;

    relu_maxpool #(.CH(CH), .COL(COL), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .cs_layer   (cs_layer),
        .d          (d),
        .q          (q),
        .q_valid    (q_valid),
        .layer_done (layer_done)
    );

    typedef struct {
        logic [QW-1:0] q;
        logic          ld;
        int            due;
        string         name;
    } exp_t;

    exp_t       sb[$];
    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         exp_cnt = 0;
    logic [3:0] tb_prev_cs = 4'd0;

    always @(posedge clk) cyc++;

    function automatic logic signed [DL-1:0] act(input int x);
`ifdef RELU_MAXPOOL_RELU_EN
        return (x < 0) ? DL'(0) : DL'(x);
`else
        return DL'(x);
`endif
    endfunction

    function automatic logic [DW-1:0] row_fill(input int v);
        logic [DW-1:0] r;
        for (int e = 0; e < CH*COL; e++) r[e*DL +: DL] = DL'(v);
        return r;
    endfunction

    function automatic logic [QW-1:0] q_fill(input logic signed [DL-1:0] v);
        logic [QW-1:0] r;
        for (int e = 0; e < CH*HC; e++) r[e*DL +: DL] = v;
        return r;
    endfunction

    task automatic chk_q(input string nm, input logic [QW-1:0] got, input logic [QW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            for (int e = 0; e < CH*HC; e++) begin
                if (got[e*DL +: DL] !== want[e*DL +: DL]) begin
                    $display("FAIL %s: q element %0d got %0d want %0d", nm, e,
                             $signed(got[e*DL +: DL]), $signed(want[e*DL +: DL]));
                    break;
                end
            end
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk_b(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    // Drive one row; when it completes a pair, queue the expected output.
    task automatic put_row(input logic [DW-1:0] row, input logic [3:0] layer,
                           input bit completes, input logic [QW-1:0] exp_q, input string nm);
        exp_t e;
        @(negedge clk);
        cs_layer = layer;
        d        = row;
        load     = 1'b1;
        if (layer != tb_prev_cs) exp_cnt = 0;
        tb_prev_cs = layer;
        if (completes) begin
            e.q    = exp_q;
            e.ld   = (exp_cnt == ROWS/2 - 1);
            e.due  = cyc + 1;
            e.name = nm;
            exp_cnt = e.ld ? 0 : exp_cnt + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic idle(input logic [3:0] layer);
        @(negedge clk);
        cs_layer = layer;
        load     = 1'b0;
        if (layer != tb_prev_cs) exp_cnt = 0;
        tb_prev_cs = layer;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt    = 0;
        tb_prev_cs = 4'd0;
        chk_q({nm, "_q"}, q, '0);
        chk_b({nm, "_q_valid"}, q_valid, 1'b0);
        chk_b({nm, "_layer_done"}, layer_done, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            exp_t m;
            m = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: q_valid missing, due cycle %0d now %0d", m.name, m.due, cyc);
        end
        if (q_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_q_valid: pulse at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_q(e.name, q, e.q);
                chk_b({e.name, "_layer_done"}, layer_done, e.ld);
                chk_i({e.name, "_cycle"}, cyc, e.due);
            end
        end else if (!rst) begin
            chk_b("layer_done_without_q_valid", layer_done, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] r1, r2;
        logic [QW-1:0] eq;

        rst      = 1'b1;
        load     = 1'b0;
        cs_layer = `LAYER0;
        d        = '0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Two positive rows: every pooled element is the larger row value.
        put_row(row_fill(5), `LAYER0, 0, '0, "");
        chk_b("first_row_no_valid", q_valid, 1'b0);
        put_row(row_fill(7), `LAYER0, 1, q_fill(7), "pair_pos");
        chk_b("latency_valid", q_valid, 1'b1);

        // All-negative pair: zero with ReLU, -3 without.
        put_row(row_fill(-3), `LAYER0, 0, '0, "");
        put_row(row_fill(-3), `LAYER0, 1, q_fill(act(-3)), "pair_neg");

        // Mixed-sign elements in channel 0 and channel 5.
        r1 = '0;
        r2 = '0;
        r1[0*DL +: DL] = DL'(1);  r1[1*DL +: DL] = DL'(9);
        r1[2*DL +: DL] = DL'(-4); r1[3*DL +: DL] = DL'(2);
        r2[0*DL +: DL] = DL'(6);  r2[1*DL +: DL] = DL'(0);
        r2[2*DL +: DL] = DL'(3);  r2[3*DL +: DL] = DL'(-8);
        r1[(COL*5+10)*DL +: DL] = DL'(-7); r1[(COL*5+11)*DL +: DL] = DL'(-2);
        r2[(COL*5+10)*DL +: DL] = DL'(-9); r2[(COL*5+11)*DL +: DL] = DL'(-5);
        eq = '0;
        eq[0*DL +: DL] = DL'(9);
        eq[1*DL +: DL] = DL'(3);
        eq[(HC*5+5)*DL +: DL] = act(-2);
        put_row(r1, `LAYER0, 0, '0, "");
        put_row(r2, `LAYER0, 1, eq, "pair_mixed");

        // Fresh layer, then twelve back-to-back rows: six outputs, the
        // sixth carrying layer_done.
        idle(`LAYER1);
        for (int r = 0; r < ROWS; r++) begin
            put_row(row_fill(10*r - 30), `LAYER1, (r % 2) == 1, q_fill(act(10*r - 30)), "burst");
        end
        chk_b("burst_last_layer_done", layer_done, 1'b1);

        // Half pair in LAYER1 is discarded when the layer changes under a load.
        put_row(row_fill(100), `LAYER1, 0, '0, "");
        put_row(row_fill(20),  `LAYER2, 0, '0, "");
        put_row(row_fill(-50), `LAYER2, 1, q_fill(act(20)), "layer_switch");

        // Loads during AFFINE produce nothing.
        put_row(row_fill(11), `AFFINE, 0, '0, "");
        put_row(row_fill(12), `AFFINE, 0, '0, "");
        chk_b("affine_no_valid", q_valid, 1'b0);
        put_row(row_fill(13), `LAYER0, 0, '0, "");
        put_row(row_fill(4),  `LAYER0, 1, q_fill(13), "after_affine");

        // Reset mid-pair discards the held row and restarts the row count.
        put_row(row_fill(50), `LAYER0, 0, '0, "");
        do_reset("reset_mid_pair");
        for (int p = 0; p < ROWS/2; p++) begin
            put_row(row_fill(-p), `LAYER0, 0, '0, "");
            put_row(row_fill(3*p), `LAYER0, 1, q_fill(DL'(3*p)), "post_reset");
        end

        repeat (3) @(negedge clk);
        chk_i("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
